// File: rtl/skip_shift_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module   : skip_shift_multiplier_if
// Purpose  : Request/response bundle for the run-skipping Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface skip_shift_multiplier_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 2)
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [CNT_W-1:0]     op_count;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, product, op_count
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, product, op_count
   );
endinterface
`default_nettype wire

// File: rtl/skip_shift_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : skip_shift_multiplier
// Purpose  : Sequential multiplier doing one add/sub per Booth run boundary.
// Revision : 1.0 - initial release
// ============================================================================
module skip_shift_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   skip_shift_multiplier_if.slave    bus
);
   localparam int CNT_W    = $clog2(WIDTH + 2);
   localparam int c_PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [c_PROD_W-1:0]   r_a_ext;
   logic [c_PROD_W-1:0]   r_acc;
   logic [c_PROD_W-1:0]   r_product;
   logic [WIDTH:0]        r_b_hi;      // b[k] for k = 0..WIDTH, extension bit on top
   logic [WIDTH:0]        r_trans;     // transitions not yet applied
   logic [CNT_W-1:0]      r_op_count;
   logic                  r_busy;
   logic                  r_done;

   logic [c_PROD_W-1:0]   w_a_ext;
   logic [WIDTH+1:0]      w_bx_in;
   logic [WIDTH:0]        w_trans_in;
   logic                  w_found;
   logic [CNT_W-1:0]      w_k;
   logic                  w_sub;
   logic [WIDTH:0]        w_rest;
   logic [c_PROD_W-1:0]   w_addend;
   logic [c_PROD_W-1:0]   w_acc_next;

   assign w_a_ext    = bus.signed_mode ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a}
                                       : {{WIDTH{1'b0}}, bus.a};
   assign w_bx_in    = {bus.signed_mode & bus.b[WIDTH-1], bus.b, 1'b0};
   assign w_trans_in = w_bx_in[WIDTH+1:1] ^ w_bx_in[WIDTH:0];

   // Lowest pending transition wins; descending scan lets it overwrite last.
   always_comb begin
      w_found = 1'b0;
      w_k     = '0;
      w_sub   = 1'b0;
      for (int i = WIDTH; i >= 0; i--) begin
         if (r_trans[i]) begin
            w_found = 1'b1;
            w_k     = CNT_W'(i);
            w_sub   = r_b_hi[i];
         end
      end
   end

   assign w_rest     = r_trans & (r_trans - (WIDTH + 1)'(1));
   assign w_addend   = r_a_ext << w_k;
   assign w_acc_next = w_sub ? (r_acc - w_addend) : (r_acc + w_addend);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_a_ext    <= '0;
         r_acc      <= '0;
         r_product  <= '0;
         r_b_hi     <= '0;
         r_trans    <= '0;
         r_op_count <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a_ext    <= w_a_ext;
                  r_b_hi     <= w_bx_in[WIDTH+1:1];
                  r_trans    <= w_trans_in;
                  r_acc      <= '0;
                  r_op_count <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_found) begin
                  r_acc      <= w_acc_next;
                  r_trans    <= w_rest;
                  r_op_count <= r_op_count + CNT_W'(1);
               end
               if (w_rest == '0) begin
                  r_product <= w_found ? w_acc_next : r_acc;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.product  = r_product;
   assign bus.op_count = r_op_count;
endmodule
`default_nettype wire

// File: tb/tb_skip_shift_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_skip_shift_multiplier
// Purpose  : Scoreboard bench for skip_shift_multiplier at WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skip_shift_multiplier;
   localparam int c_MAX_LAT = 40;

   typedef struct {
      logic [15:0] prod;
      int          cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   skip_shift_multiplier_if #(.WIDTH(8)) bus ();

   skip_shift_multiplier #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: plain multiplication plus a bitwise transition count.
   function automatic exp_t model(input logic sm, input logic [7:0] aa, input logic [7:0] bb);
      exp_t        e;
      logic [9:0]  bx;
      logic [15:0] ax, bw;
      ax = sm ? {{8{aa[7]}}, aa} : {8'h00, aa};
      bw = sm ? {{8{bb[7]}}, bb} : {8'h00, bb};
      e.prod = ax * bw;
      bx = {sm & bb[7], bb, 1'b0};
      e.cnt = 0;
      for (int i = 0; i <= 8; i++) if (bx[i+1] != bx[i]) e.cnt++;
      return e;
   endfunction

   task automatic drive_op(input logic sm, input logic [7:0] aa, input logic [7:0] bb,
                           input exp_t e, input bit hold, input bit scramble,
                           output logic [15:0] prod, output int cnt, output int lat,
                           output int bsy, output logic again, output bit to);
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b1; bus.signed_mode = sm; bus.a = aa; bus.b = bb;
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      lat = 0; bsy = 0;
      while (bus.done !== 1'b1 && lat < c_MAX_LAT) begin
         if (bus.busy === 1'b1) bsy++;
         lat++;
         if (scramble) begin
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.signed_mode = 1'($urandom);
         end
         @(negedge clk);
      end
      to   = (lat >= c_MAX_LAT);
      prod = bus.product;
      cnt  = int'(bus.op_count);
      bus.start = 1'b0;
      @(negedge clk);
      again = bus.done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0)    begin n_err++; $display("FAIL reset busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0)    begin n_err++; $display("FAIL reset done: got %b want 0", bus.done); end
      n_cmp++; if (bus.product !== 16'h0) begin n_err++; $display("FAIL reset product: got %h want 0", bus.product); end
      n_cmp++; if (bus.op_count !== 4'h0) begin n_err++; $display("FAIL reset op_count: got %0d want 0", bus.op_count); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic        sm_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0]  a_t  [6] = '{8'd3, 8'd3, 8'hFD, 8'hFF, 8'h80, 8'h00};
      logic [7:0]  b_t  [6] = '{8'h00, 8'hFB, 8'hFB, 8'hFF, 8'h80, 8'hFB};
      logic [15:0] p_t  [6] = '{16'd0, 16'd753, 16'd15, 16'd65025, 16'd16384, 16'd0};
      int          c_t  [6] = '{0, 4, 3, 2, 1, 4};
      logic [15:0] prod; int cnt, lat, bsy; logic again; bit to; exp_t e, x;
      for (int i = 0; i < 6; i++) begin
         e.prod = p_t[i]; e.cnt = c_t[i];
         drive_op(sm_t[i], a_t[i], b_t[i], e, 1'b0, 1'b0, prod, cnt, lat, bsy, again, to);
         x = sb.pop_front();
         n_cmp++; if (to) begin n_err++; $display("FAIL dir%0d timeout: no done within %0d cycles", i, c_MAX_LAT); end
         n_cmp++; if (prod !== x.prod) begin n_err++; $display("FAIL dir%0d product: got %0d want %0d", i, prod, x.prod); end
         n_cmp++; if (cnt != x.cnt) begin n_err++; $display("FAIL dir%0d op_count: got %0d want %0d", i, cnt, x.cnt); end
         n_cmp++; if (lat != ((x.cnt > 0) ? x.cnt : 1)) begin n_err++; $display("FAIL dir%0d latency: got %0d want %0d", i, lat, (x.cnt > 0) ? x.cnt : 1); end
         n_cmp++; if (bsy != lat) begin n_err++; $display("FAIL dir%0d busy cycles: got %0d want %0d", i, bsy, lat); end
         n_cmp++; if (again !== 1'b0) begin n_err++; $display("FAIL dir%0d done width: got %b want 0 next cycle", i, again); end
      end
   endtask

   task automatic test_reset_abort();
      int extra = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 8'd3; bus.b = 8'hFB;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0)    begin n_err++; $display("FAIL abort busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0)    begin n_err++; $display("FAIL abort done: got %b want 0", bus.done); end
      n_cmp++; if (bus.product !== 16'h0) begin n_err++; $display("FAIL abort product: got %0d want 0", bus.product); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      end
      n_cmp++; if (extra != 0) begin n_err++; $display("FAIL abort residue: got %0d active cycles want 0", extra); end
   endtask

   task automatic test_start_ignored();
      logic [15:0] prod; int cnt, lat, bsy, extra; logic again; bit to; exp_t x;
      drive_op(1'b0, 8'd3, 8'hFB, model(1'b0, 8'd3, 8'hFB), 1'b1, 1'b1, prod, cnt, lat, bsy, again, to);
      x = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL hold timeout: no done within %0d cycles", c_MAX_LAT); end
      n_cmp++; if (prod !== 16'd753) begin n_err++; $display("FAIL hold product: got %0d want 753", prod); end
      n_cmp++; if (cnt != x.cnt) begin n_err++; $display("FAIL hold op_count: got %0d want %0d", cnt, x.cnt); end
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
         @(negedge clk);
      end
      n_cmp++; if (again !== 1'b0 || extra != 0) begin n_err++; $display("FAIL hold requeue: got %0d extra active cycles want 0", extra + int'(again)); end
   endtask

   task automatic test_random();
      logic [15:0] prod; int cnt, lat, bsy; logic again; bit to; exp_t x;
      logic sm; logic [7:0] aa, bb;
      for (int n = 0; n < 3000; n++) begin
         sm = 1'($urandom); aa = 8'($urandom); bb = 8'($urandom);
         drive_op(sm, aa, bb, model(sm, aa, bb), 1'b0, 1'b1, prod, cnt, lat, bsy, again, to);
         x = sb.pop_front();
         n_cmp++;
         if (to || prod !== x.prod || cnt != x.cnt || lat != ((x.cnt > 0) ? x.cnt : 1) ||
             bsy != lat || again !== 1'b0) begin
            n_err++;
            $display("FAIL rnd%0d sm=%b a=%h b=%h: got prod=%0d cnt=%0d lat=%0d busy=%0d to=%0b want prod=%0d cnt=%0d lat=%0d",
                     n, sm, aa, bb, prod, cnt, lat, bsy, to, x.prod, x.cnt, (x.cnt > 0) ? x.cnt : 1);
         end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
      test_reset();
      test_directed();
      test_reset_abort();
      test_start_ignored();
      test_random();
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard residue: got %0d entries want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
